// File: rtl/spi_regif_pkg.sv
// Shared types and constants for the SPI register interface.
// Holds the frame FSM state enum, the R/W encoding and the SCLK ratio limit.
package spi_regif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ADDR,
    DATA
  } spi_state_e;

  localparam logic RW_WRITE     = 1'b1;
  localparam int   MIN_SCLK_DIV = 8;

endpackage

// File: rtl/spi_regif_sync.sv
// Multi-flop synchroniser with rise/fall pulse detection on the synced level.
// Ports: clk, rst (async, high), d (async in), q (synced), rise/fall (1-clk pulses).
module spi_regif_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] ff;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff   <= '0;
      prev <= 1'b0;
    end else begin
      ff   <= {ff[STAGES-2:0], d};
      prev <= ff[STAGES-1];
    end
  end

  assign q    = ff[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave bridging an external master to the register file.
// Frame: R/W bit, ADDR_W address bits, then DATA_W-bit words, MSB first.
// Ports: clk_i/rst_i, SPI pads sclk_i/cs_i/mosi_i/miso_o, register side
// reg_addr_o/reg_wdata_o/reg_we_o/reg_re_o/reg_rdata_i.
// Macro SPI_REGIF_BURST_EN: address auto-increment and read prefetch;
// when undefined a frame carries a single data word.
module spi_regif
  import spi_regif_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              reg_we_o,
  output logic              reg_re_o
);

`ifdef SPI_REGIF_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAXW + 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_regif_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk  (clk_i),
    .rst  (rst_i),
    .d    (sclk_i),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_regif_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk  (clk_i),
    .rst  (rst_i),
    .d    (cs_i),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_regif_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk  (clk_i),
    .rst  (rst_i),
    .d    (mosi_i),
    .q    (mosi_q),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, cs_q, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              rw_q;
  logic              done_q;
  logic              re_go;
  logic              cap_q;
  logic              inc_q;

  logic [ADDR_W:0]   addr_cat;
  logic [DATA_W:0]   rx_cat;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] rx_nx;
  logic              addr_last;
  logic              data_last;

  assign addr_cat  = {addr_sh, mosi_q};
  assign rx_cat    = {rx_sh, mosi_q};
  assign addr_nx   = addr_cat[ADDR_W-1:0];
  assign rx_nx     = rx_cat[DATA_W-1:0];
  assign addr_last = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD:  if (sclk_rise) state_d = ADDR;
      ADDR: if (sclk_rise && addr_last) state_d = DATA;
      DATA: state_d = DATA;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt     <= '0;
      addr_sh     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      re_go       <= 1'b0;
      cap_q       <= 1'b0;
      inc_q       <= 1'b0;
      miso_o      <= 1'b0;
      reg_wdata_o <= '0;
      reg_addr_o  <= '0;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
    end else begin
      reg_we_o <= 1'b0;
      reg_re_o <= re_go;
      re_go    <= 1'b0;
      inc_q    <= 1'b0;
      cap_q    <= reg_re_o;
      // CS rise outranks a coincident final SCLK rise: the word is dropped.
      if (cs_rise || state_q == IDLE) begin
        bit_cnt <= '0;
        done_q  <= 1'b0;
        tx_sh   <= '0;
        miso_o  <= 1'b0;
        re_go   <= 1'b0;
      end else begin
        unique case (state_q)
          CMD: if (sclk_rise) begin
            rw_q    <= mosi_q;
            bit_cnt <= '0;
          end
          ADDR: if (sclk_rise) begin
            addr_sh <= addr_nx;
            bit_cnt <= bit_cnt + 1'b1;
            if (addr_last) begin
              bit_cnt    <= '0;
              reg_addr_o <= addr_nx;
              re_go      <= (rw_q != RW_WRITE);
            end
          end
          DATA: begin
            // Writes bump the address one cycle after the strobe so the
            // strobe sees the address of the word it carries.
            if (inc_q) reg_addr_o <= reg_addr_o + ADDR_W'(1);
            if (cap_q) tx_sh <= reg_rdata_i;
            if (sclk_fall) begin
              miso_o <= done_q ? 1'b0 : tx_sh[DATA_W-1];
              tx_sh  <= tx_sh << 1;
            end
            if (sclk_rise && !done_q) begin
              rx_sh   <= rx_nx;
              bit_cnt <= bit_cnt + 1'b1;
              if (data_last) begin
                bit_cnt <= '0;
                done_q  <= !BURST;
                if (rw_q == RW_WRITE) begin
                  reg_wdata_o <= rx_nx;
                  reg_we_o    <= 1'b1;
                  inc_q       <= BURST;
                end else if (BURST) begin
                  // Prefetch the next word so its MSB is ready by the next fall.
                  reg_addr_o <= reg_addr_o + ADDR_W'(1);
                  re_go      <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_regif.sv
// Self-checking bench for spi_regif: default 7/8 instance plus a 10/16 instance.
// Scoreboard queues hold expected register strobes; monitors pop and compare.
module tb_spi_regif;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic cs = 1'b1, sclk = 1'b0, mosi = 1'b0;

  logic cs_a, sclk_a, mosi_a, miso_a, we_a, re_a;
  logic [7:0] rdata_a, wdata_a;
  logic [6:0] addr_a;

  logic cs_b, sclk_b, mosi_b, miso_b, we_b, re_b;
  logic [15:0] rdata_b, wdata_b;
  logic [9:0] addr_b;

  assign cs_a   = sel ? 1'b1 : cs;
  assign sclk_a = sel ? 1'b0 : sclk;
  assign mosi_a = sel ? 1'b0 : mosi;
  assign cs_b   = sel ? cs : 1'b1;
  assign sclk_b = sel ? sclk : 1'b0;
  assign mosi_b = sel ? mosi : 1'b0;

  spi_regif dut_a (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk_a), .cs_i(cs_a),
    .mosi_i(mosi_a), .miso_o(miso_a), .reg_rdata_i(rdata_a),
    .reg_wdata_o(wdata_a), .reg_addr_o(addr_a),
    .reg_we_o(we_a), .reg_re_o(re_a)
  );

  spi_regif #(.ADDR_W(10), .DATA_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk_b), .cs_i(cs_b),
    .mosi_i(mosi_b), .miso_o(miso_b), .reg_rdata_i(rdata_b),
    .reg_wdata_o(wdata_b), .reg_addr_o(addr_b),
    .reg_we_o(we_b), .reg_re_o(re_b)
  );

`ifdef SPI_REGIF_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [14:0] wq_a[$];
  logic [6:0]  rq_a[$];
  logic [9:0]  rq_b[$];

  always @(posedge clk) begin
    if (re_a) rdata_a <= (addr_a == 7'h22) ? 8'h3C : 8'hC3;
    if (re_b) rdata_b <= ~{6'b0, addr_b};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (we_a && re_a) begin
        n_cmp++; n_err++;
        $display("FAIL strobe_overlap_a: we and re both high");
      end
      if (we_a) begin
        n_cmp++;
        if (wq_a.size() == 0) begin
          n_err++;
          $display("FAIL write_a: got addr=%h data=%h, required no write",
                   addr_a, wdata_a);
        end else begin
          logic [14:0] e;
          e = wq_a.pop_front();
          if ({addr_a, wdata_a} !== e) begin
            n_err++;
            $display("FAIL write_a: got addr=%h data=%h, required addr=%h data=%h",
                     addr_a, wdata_a, e[14:8], e[7:0]);
          end
        end
      end
      if (re_a) begin
        n_cmp++;
        if (rq_a.size() == 0) begin
          n_err++;
          $display("FAIL read_a: got re at %h, required no read", addr_a);
        end else begin
          logic [6:0] e;
          e = rq_a.pop_front();
          if (addr_a !== e) begin
            n_err++;
            $display("FAIL read_a: got addr=%h, required %h", addr_a, e);
          end
        end
      end
      if (we_b) begin
        n_cmp++; n_err++;
        $display("FAIL write_b: got addr=%h data=%h, required no write",
                 addr_b, wdata_b);
      end
      if (re_b) begin
        n_cmp++;
        if (rq_b.size() == 0) begin
          n_err++;
          $display("FAIL read_b: got re at %h, required no read", addr_b);
        end else begin
          logic [9:0] e;
          e = rq_b.pop_front();
          if (addr_b !== e) begin
            n_err++;
            $display("FAIL read_b: got addr=%h, required %h", addr_b, e);
          end
        end
      end
    end
  end

  task automatic spi_xfer(input bit s, input int nbits,
                          input logic [63:0] tx, input bit keep_cs,
                          output logic [63:0] rx);
    rx = '0;
    @(negedge clk);
    sel = s;
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      rx[i] = s ? miso_b : miso_a;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    if (!keep_cs) begin
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic check_queues(input string name);
    n_cmp++;
    if (wq_a.size() !== 0 || rq_a.size() !== 0 || rq_b.size() !== 0) begin
      n_err++;
      $display("FAIL %s_pending: got wq=%0d rqa=%0d rqb=%0d left, required 0",
               name, wq_a.size(), rq_a.size(), rq_b.size());
    end
    wq_a.delete(); rq_a.delete(); rq_b.delete();
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({miso_a, wdata_a, addr_a, we_a, re_a} !== '0) begin
      n_err++;
      $display("FAIL %s_a: got miso=%b wdata=%h addr=%h we=%b re=%b, required all 0",
               name, miso_a, wdata_a, addr_a, we_a, re_a);
    end
    n_cmp++;
    if ({miso_b, wdata_b, addr_b, we_b, re_b} !== '0) begin
      n_err++;
      $display("FAIL %s_b: got miso=%b wdata=%h addr=%h we=%b re=%b, required all 0",
               name, miso_b, wdata_b, addr_b, we_b, re_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_zero("post_reset");
  endtask

  task automatic test_write();
    logic [63:0] rx;
    wq_a.push_back({7'h15, 8'hA5});
    spi_xfer(1'b0, 16, {48'b0, 1'b1, 7'h15, 8'hA5}, 1'b0, rx);
    check_queues("write");
  endtask

  task automatic test_read();
    logic [63:0] rx;
    rq_a.push_back(7'h22);
    if (BURST) rq_a.push_back(7'h23);
    spi_xfer(1'b0, 16, {48'b0, 1'b0, 7'h22, 8'h00}, 1'b0, rx);
    n_cmp++;
    if (rx[7:0] !== 8'h3C) begin
      n_err++;
      $display("FAIL read_miso: got %h, required 3c", rx[7:0]);
    end
    n_cmp++;
    if (rx[15:8] !== 8'h00) begin
      n_err++;
      $display("FAIL read_miso_hdr: got %h, required 00", rx[15:8]);
    end
    check_queues("read");
  endtask

  task automatic test_burst_write();
    logic [63:0] rx;
    wq_a.push_back({7'h7E, 8'h11});
    if (BURST) begin
      wq_a.push_back({7'h7F, 8'h22});
      wq_a.push_back({7'h00, 8'h33});
    end
    spi_xfer(1'b0, 32, {32'b0, 1'b1, 7'h7E, 8'h11, 8'h22, 8'h33}, 1'b0, rx);
    check_queues("burst_write");
  endtask

  task automatic test_abort();
    logic [63:0] rx;
    spi_xfer(1'b0, 13, {51'b0, 1'b1, 7'h01, 5'b10101}, 1'b0, rx);
    check_queues("abort");
    wq_a.push_back({7'h02, 8'h5A});
    spi_xfer(1'b0, 16, {48'b0, 1'b1, 7'h02, 8'h5A}, 1'b0, rx);
    check_queues("after_abort");
  endtask

  task automatic test_sweep();
    logic [63:0] rx;
    logic [15:0] exp2;
    rq_b.push_back(10'h3FF);
    if (BURST) begin
      rq_b.push_back(10'h000);
      rq_b.push_back(10'h001);
    end
    exp2 = BURST ? 16'hFFFF : 16'h0000;
    spi_xfer(1'b1, 43, {21'b0, 1'b0, 10'h3FF, 32'b0}, 1'b0, rx);
    n_cmp++;
    if (rx[31:16] !== 16'hFC00) begin
      n_err++;
      $display("FAIL sweep_word0: got %h, required fc00", rx[31:16]);
    end
    n_cmp++;
    if (rx[15:0] !== exp2) begin
      n_err++;
      $display("FAIL sweep_word1: got %h, required %h", rx[15:0], exp2);
    end
    check_queues("sweep");
  endtask

  task automatic test_reset_mid();
    logic [63:0] rx;
    spi_xfer(1'b0, 5, {59'b0, 1'b1, 4'b0000}, 1'b1, rx);
    rst = 1'b1;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_queues("reset_mid");
    wq_a.push_back({7'h05, 8'h77});
    spi_xfer(1'b0, 16, {48'b0, 1'b1, 7'h05, 8'h77}, 1'b0, rx);
    check_queues("after_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst_write();
    test_abort();
    test_sweep();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
